// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// The master issues op/a/b and consumes result; the slave is the arithmetic unit.
// Both directions use valid/ready flow control.
interface muldiv_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency XLEN+1 cycles from accept to out_valid; div-by-zero/overflow in 1 cycle.
// Result held in DONE until out_ready; in_ready only in IDLE; kill aborts to IDLE.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kill,
    muldiv_iter_if.slave io
);
    localparam int              CNT_W   = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;        // {hi, lo}: product, or {remainder, dividend/quotient}
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d; // negate product / quotient
    logic              neg_rem_q, neg_rem_d; // negate remainder (sign of a)
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.result    = result_q;

    // Decode the incoming request: operand signedness, magnitudes and fast-path cases
    always_comb begin
        a_signed = (io.op != 3'd3) && (io.op != 3'd5) && (io.op != 3'd7);
        b_signed = (io.op == 3'd0) || (io.op == 3'd1) || (io.op == 3'd4) || (io.op == 3'd6);
        neg_a    = a_signed && io.a[XLEN-1];
        neg_b    = b_signed && io.b[XLEN-1];
        // INT_MIN negates to itself, which read as unsigned is its true magnitude
        mag_a    = neg_a ? -io.a : io.a;
        mag_b    = neg_b ? -io.b : io.b;
        div_zero = io.op[2] && (io.b == '0);
        div_ovf  = ((io.op == 3'd4) || (io.op == 3'd6)) && (io.a == INT_MIN) && (io.b == '1);
        fast_res = '0;
        if (div_zero) begin
            fast_res = io.op[1] ? io.a : '1;
        end else if (div_ovf) begin
            fast_res = io.op[1] ? '0 : io.a;
        end
    end

    // One radix-2 step of the datapath plus the sign-fixed final result
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        q_bit     = ~div_diff[XLEN];
        if (op_q[2]) begin
            acc_step = {(q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], q_bit};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = neg_res_q ? -acc_step : acc_step;
        quo  = neg_res_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            final_res = op_q[1] ? rem : quo;
        end else begin
            final_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath register updates; kill overrides everything
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        op_d      = io.op;
                        neg_res_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        if (div_zero || div_ovf) begin
                            result_d = fast_res;
                            state_d  = DONE;
                        end else begin
                            opnd_d  = io.op[2] ? mag_b : mag_a;
                            acc_d   = {{XLEN{1'b0}}, (io.op[2] ? mag_a : mag_b)};
                            cnt_d   = CNT_W'(XLEN);
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at XLEN=32: results, latency, backpressure, kill, reset.
module tb_muldiv_iter;
    logic clk;
    logic rst;
    logic kill;
    int   n_chk;
    int   n_pass;

    muldiv_iter_if #(.XLEN(32)) io ();

    muldiv_iter #(.XLEN(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .kill (kill),
        .io   (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        int n;
        n = 0;
        while (!io.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("issue_timeout", 32'd0, 32'd1);
        io.op       = o;
        io.a        = av;
        io.b        = bv;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    // Cycle count from accept (cycle 0) to the first cycle out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!io.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(o, av, bv);
        wait_out(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk(tag, io.result, exp);
        if (io.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat;
        int bad_v;
        int bad_r;
        int bad_i;
        int seen;
        n_chk        = 0;
        n_pass       = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        kill         = 1'b0;
        io.in_valid  = 1'b0;
        io.op        = 3'd0;
        io.a         = '0;
        io.b         = '0;
        io.out_ready = 1'b1;

        #1;
        chk("rst_in_ready", 32'(io.in_ready), 32'd1);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_result", io.result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // multiply family
        do_op("mul_ff",     3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        do_op("mulhu_ff",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        do_op("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        do_op("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        do_op("mul_neg",    3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 33);

        // divide family
        do_op("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
        do_op("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
        do_op("divu_big",   3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33);
        do_op("div_7_m2",   3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        do_op("rem_7_m2",   3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);
        do_op("remu_100_7", 3'd7, 32'd100,      32'd7,        32'd2,        33);

        // fast paths
        do_op("div_by0",    3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op("rem_by0",    3'd6, 32'd5,        32'd0,        32'd5,        1);
        do_op("divu_by0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // backpressure: hold result in DONE for 10 cycles
        io.out_ready = 1'b0;
        issue(3'd0, 32'd6, 32'd7);
        chk("calc_in_ready", 32'(io.in_ready), 32'd0);
        wait_out(lat);
        chk("bp_lat", 32'(lat), 32'd33);
        bad_v = 0;
        bad_r = 0;
        bad_i = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (io.out_valid !== 1'b1) bad_v++;
            if (io.result !== 32'd42) bad_r++;
            if (io.in_ready !== 1'b0) bad_i++;
        end
        chk("bp_valid_held", 32'(bad_v), 32'd0);
        chk("bp_result_held", 32'(bad_r), 32'd0);
        chk("bp_in_ready_low", 32'(bad_i), 32'd0);
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(io.in_ready), 32'd1);
        chk("bp_release_valid", 32'(io.out_valid), 32'd0);

        // kill at cycle 10 of a divide
        issue(3'd4, 32'd100, 32'd3);
        repeat (9) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        chk("kill_in_ready", 32'(io.in_ready), 32'd1);
        chk("kill_out_valid", 32'(io.out_valid), 32'd0);
        // request presented together with kill must be dropped
        io.op       = 3'd4;
        io.a        = 32'd5;
        io.b        = 32'd0;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        kill        = 1'b0;
        chk("kill_drop_valid", 32'(io.out_valid), 32'd0);
        chk("kill_drop_ready", 32'(io.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (io.out_valid) seen++;
        end
        chk("kill_no_output", 32'(seen), 32'd0);
        do_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        // asynchronous reset in the middle of CALC
        issue(3'd0, 32'd9, 32'd9);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("mid_rst_result", io.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("post_rst_remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
